nes_pad_responder: RTL and testbench

- Emulates an NES controller on the NES serial link, acting as the responder to our NES controller reader.
- Samples an 8-bit active-high button vector when latch is asserted, then shifts bits out active-low on nes_data, one per rising edge of pulse.
- Used to drive a second Nexys4 or the on-board reader in loopback, so the reader and game logic can be exercised without a physical pad.
- Raw latch/pulse inputs are asynchronous to sysclk; they are synchronized and glitch-filtered internally.

---
 rtl/nes_pkg.sv | 31 +++
 rtl/nes_input_filter.sv | 49 ++++
 rtl/nes_pad_responder.sv | 128 ++++++++++++
 tb/tb_nes_pad_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nes_pkg
// Purpose  : Button bit positions and responder state encoding for the NES link
// Revision : 1.0 - initial release
// ============================================================================
package nes_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } nes_state_t;

endpackage
`default_nettype wire

// File: rtl/nes_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : nes_input_filter
// Purpose  : Synchronizes an async input and commits a new level only after
//            FILTER_CYCLES consecutive differing samples
// Revision : 1.0 - initial release
// ============================================================================
module nes_input_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic sysclk,
    input  logic sysreset,
    input  logic din,
    output logic dout
);

    localparam int             CW         = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0]  c_last_cnt = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   w_sample;

    assign w_sample = r_sync[SYNC_STAGES-1];
    assign dout     = r_level;

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            // Any sample matching the current level restarts the stability count.
            if (w_sample == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last_cnt) begin
                r_level <= w_sample;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nes_pad_responder.sv
`default_nettype none
// ============================================================================
// Module   : nes_pad_responder
// Purpose  : NES controller emulator - latches buttons, shifts them out
//            active-low on each filtered pulse rise
// Revision : 1.0 - initial release
// ============================================================================
module nes_pad_responder
    import nes_pkg::*;
#(
    parameter int NUM_BUTTONS   = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                   sysclk,
    input  logic                   sysreset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   nes_latch,
    input  logic                   nes_pulse,
    output logic                   nes_data,
    output logic                   poll_done,
    output logic [CNT_WIDTH-1:0]   poll_count
);

    localparam int            IW         = $clog2(NUM_BUTTONS + 1);
    localparam logic [IW-1:0] c_idx_last = IW'(NUM_BUTTONS);

    logic                   w_latch_f;
    logic                   w_pulse_f;
    logic                   w_pulse_rise;
    logic                   r_pulse_d;

    nes_state_t             r_state,  w_state_nxt;
    logic [NUM_BUTTONS-1:0] r_shreg,  w_shreg_nxt;
    logic [IW-1:0]          r_idx,    w_idx_nxt;
    logic                   r_data,   w_data_nxt;
    logic                   r_done,   w_done_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt,    w_cnt_nxt;

    nes_input_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_latch_filt (
        .sysclk   (sysclk),
        .sysreset (sysreset),
        .din      (nes_latch),
        .dout     (w_latch_f)
    );

    nes_input_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_pulse_filt (
        .sysclk   (sysclk),
        .sysreset (sysreset),
        .din      (nes_pulse),
        .dout     (w_pulse_f)
    );

    assign w_pulse_rise = w_pulse_f & ~r_pulse_d;

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            r_pulse_d <= 1'b0;
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_idx     <= '0;
            r_data    <= 1'b1;
            r_done    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_pulse_d <= w_pulse_f;
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_idx     <= w_idx_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // r_idx is the 1-based number of the bit currently on the line; the rise
    // seen while the last bit is presented completes the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        if (w_latch_f) begin
            w_state_nxt = S_LOAD;
            w_shreg_nxt = buttons;
            w_data_nxt  = ~buttons[0];
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: w_data_nxt = 1'b1;
                S_LOAD: begin
                    w_state_nxt = S_SHIFT;
                    w_idx_nxt   = IW'(1);
                end
                S_SHIFT: begin
                    if (w_pulse_rise) begin
                        w_shreg_nxt = r_shreg >> 1;
                        w_data_nxt  = ~w_shreg_nxt[0];
                        if (r_idx == c_idx_last) begin
                            w_done_nxt  = 1'b1;
                            w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end
                end
                S_DONE:  w_data_nxt  = 1'b1;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign nes_data   = r_data;
    assign poll_done  = r_done;
    assign poll_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_pad_responder
// Purpose  : Directed self-checking bench for nes_pad_responder (CNT_WIDTH=4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_pad_responder;

    localparam int LAT    = 20;
    localparam int HI     = 12;
    localparam int LO     = 12;
    localparam int SETTLE = 12;

    logic       sysclk;
    logic       sysreset;
    logic [7:0] buttons;
    logic       nes_latch;
    logic       nes_pulse;
    logic       nes_data;
    logic       poll_done;
    logic [3:0] poll_count;

    int         checks;
    int         errors;
    int         done_seen;
    int         exp_done;
    logic [3:0] exp_cnt;

    nes_pad_responder #(
        .NUM_BUTTONS   (8),
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .CNT_WIDTH     (4)
    ) dut (
        .sysclk     (sysclk),
        .sysreset   (sysreset),
        .buttons    (buttons),
        .nes_latch  (nes_latch),
        .nes_pulse  (nes_pulse),
        .nes_data   (nes_data),
        .poll_done  (poll_done),
        .poll_count (poll_count)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) if (poll_done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Latch high for LAT cycles; optionally check the exact 7-cycle latency.
    task automatic do_latch(input bit chk_lat, input logic exp0);
        nes_latch = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge sysclk);
            if (chk_lat && c == 6) chk("latch_lat6", {31'd0, nes_data}, 32'd1);
            if (chk_lat && c == 7) chk("latch_lat7", {31'd0, nes_data}, {31'd0, exp0});
        end
        nes_latch = 1'b0;
        repeat (SETTLE) @(negedge sysclk);
    endtask

    // One pulse; optionally check poll_done lands exactly 7 cycles after the rise.
    task automatic do_pulse(input bit chk_done);
        nes_pulse = 1'b1;
        for (int c = 1; c <= HI; c++) begin
            @(negedge sysclk);
            if (chk_done && c == 6) chk("done_early", {31'd0, poll_done}, 32'd0);
            if (chk_done && c == 7) chk("done_strobe", {31'd0, poll_done}, 32'd1);
            if (chk_done && c == 8) chk("done_width", {31'd0, poll_done}, 32'd0);
        end
        nes_pulse = 1'b0;
        repeat (LO) @(negedge sysclk);
    endtask

    // exp[0] = nes_data after latch, exp[k] = nes_data after rise k.
    task automatic run_frame(input logic [7:0] btn, input logic [8:0] exp,
                             input int chg, input logic [7:0] newb, input bit chk_lat);
        buttons = btn;
        do_latch(chk_lat, exp[0]);
        chk("bit_post_latch", {31'd0, nes_data}, {31'd0, exp[0]});
        for (int k = 1; k <= 8; k++) begin
            if (k == chg) buttons = newb;
            do_pulse(k == 8);
            chk($sformatf("bit_after_rise%0d", k), {31'd0, nes_data}, {31'd0, exp[k]});
        end
        exp_cnt = exp_cnt + 4'd1;
        exp_done++;
        chk("poll_count", {28'd0, poll_count}, {28'd0, exp_cnt});
    endtask

    task automatic quick_frame(input logic [7:0] btn);
        buttons = btn;
        do_latch(1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) do_pulse(1'b0);
        exp_cnt = exp_cnt + 4'd1;
        exp_done++;
        chk("quick_count", {28'd0, poll_count}, {28'd0, exp_cnt});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        done_seen = 0;
        exp_done  = 0;
        exp_cnt   = 4'd0;
        sysreset  = 1'b0;
        buttons   = 8'h00;
        nes_latch = 1'b0;
        nes_pulse = 1'b0;

        // Reset held with inputs toggling
        for (int i = 0; i < 24; i++) begin
            @(negedge sysclk);
            nes_latch = i[1];
            nes_pulse = i[0];
            if (i % 6 == 5) begin
                chk("rst_data", {31'd0, nes_data}, 32'd1);
                chk("rst_done", {31'd0, poll_done}, 32'd0);
                chk("rst_count", {28'd0, poll_count}, 32'd0);
            end
        end
        nes_latch = 1'b0;
        nes_pulse = 1'b0;
        @(negedge sysclk);
        sysreset = 1'b1;
        repeat (20) @(negedge sysclk);
        chk("post_rst_data", {31'd0, nes_data}, 32'd1);
        chk("post_rst_count", {28'd0, poll_count}, 32'd0);

        // buttons=01: only A pressed, with latency checks
        run_frame(8'h01, 9'b111111110, 0, 8'h00, 1'b1);
        chk("done_once", done_seen, 32'd1);
        do_pulse(1'b0);
        chk("ninth_pulse_data", {31'd0, nes_data}, 32'd1);
        chk("ninth_pulse_count", {28'd0, poll_count}, 32'd1);

        // buttons=A5, changed to FF after the third rise
        run_frame(8'hA5, 9'b101011010, 4, 8'hFF, 1'b0);

        // Abort: 3 pulses then a new latch with buttons=80
        buttons = 8'h01;
        do_latch(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) do_pulse(1'b0);
        run_frame(8'h80, 9'b101111111, 0, 8'h00, 1'b0);
        chk("abort_done_total", done_seen, exp_done);

        // Glitch rejection in SHIFT with buttons=A5
        buttons = 8'hA5;
        do_latch(1'b0, 1'b0);
        chk("glitch_start", {31'd0, nes_data}, 32'd0);
        nes_pulse = 1'b1;
        repeat (3) @(negedge sysclk);
        nes_pulse = 1'b0;
        repeat (SETTLE) @(negedge sysclk);
        chk("glitch3_ignored", {31'd0, nes_data}, 32'd0);
        nes_pulse = 1'b1;
        repeat (4) @(negedge sysclk);
        nes_pulse = 1'b0;
        repeat (SETTLE) @(negedge sysclk);
        chk("glitch4_shift", {31'd0, nes_data}, 32'd1);
        do_pulse(1'b0);
        chk("glitch_next_bit", {31'd0, nes_data}, 32'd0);
        for (int k = 0; k < 6; k++) do_pulse(1'b0);
        exp_cnt = exp_cnt + 4'd1;
        exp_done++;
        chk("glitch_frame_count", {28'd0, poll_count}, {28'd0, exp_cnt});

        // Wrap: advance to 15, then the next poll wraps to 0 with poll_done
        for (int n = 0; n < 20 && exp_cnt != 4'd15; n++) quick_frame(8'h3C);
        chk("pre_wrap_count", {28'd0, poll_count}, 32'd15);
        run_frame(8'h00, 9'b111111111, 0, 8'h00, 1'b0);
        chk("wrap_count_zero", {28'd0, poll_count}, 32'd0);
        chk("done_total", done_seen, exp_done);

        // Reset mid-frame
        buttons = 8'h01;
        do_latch(1'b0, 1'b0);
        do_pulse(1'b0);
        chk("pre_midrst_count", {28'd0, poll_count}, 32'd0);
        sysreset = 1'b0;
        #1;
        chk("midrst_data", {31'd0, nes_data}, 32'd1);
        chk("midrst_done", {31'd0, poll_done}, 32'd0);
        repeat (3) @(negedge sysclk);
        sysreset = 1'b1;
        repeat (SETTLE) @(negedge sysclk);
        chk("midrst_idle_data", {31'd0, nes_data}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
